// File: rtl/fb_pkg.sv
// Frame-buffer shared types and geometry.
// 160x120 RGB444 image, upscaled 4x at scan-out.
package fb_pkg;

  localparam int PIX_W    = 12;
  localparam int FB_W     = 160;
  localparam int FB_H     = 120;
  localparam int FB_DEPTH = FB_W * FB_H;
  localparam int ADDR_W   = 15;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VB,
    LOAD
  } fb_arb_state_t;

  typedef logic [PIX_W-1:0] pixel_t;

endpackage

// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer arbiter: scan-out reads beat loader writes.
// Loader sessions can be held until vblank so frames never tear.
module fb_port_arbiter #(
  parameter int PIX_W           = fb_pkg::PIX_W,
  parameter int FB_DEPTH        = fb_pkg::FB_DEPTH,
  parameter int ADDR_W          = fb_pkg::ADDR_W,
  parameter bit WAIT_FOR_VBLANK = 1'b1
) (
  input  logic              clk_100MHz,
  input  logic              reset_n,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PIX_W-1:0]  rd_data,
  output logic              rd_valid,
  input  logic              vblank,
  input  logic              load_req,
  output logic              load_gnt,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  output logic              frame_done,
  output logic [ADDR_W:0]   wr_count,
  output logic              addr_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [PIX_W-1:0]  mem_wdata,
  input  logic [PIX_W-1:0]  mem_rdata
);

  import fb_pkg::*;

  localparam logic [ADDR_W:0] DEPTH_C = FB_DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};

  fb_arb_state_t   state;
  logic            vblank_q;
  logic            vb_rise;
  logic            rd_in;
  logic            wr_in;
  logic            wr_acc;
  logic [ADDR_W:0] cnt_nxt;
  logic            rd_p1;
  logic            rd_ok1;

  assign vb_rise  = vblank & ~vblank_q;
  assign rd_in    = {1'b0, rd_addr} < DEPTH_C;
  assign wr_in    = {1'b0, wr_addr} < DEPTH_C;
  assign load_gnt = (state == LOAD);

  // Reads always win; the loader holds its beat until a free cycle.
  assign wr_ready = load_gnt & ~rd_req;
  assign wr_acc   = wr_valid & wr_ready;

  assign mem_en    = (rd_req & rd_in) | (wr_acc & wr_in);
  assign mem_we    = wr_acc & wr_in;
  assign mem_addr  = rd_req ? rd_addr : wr_addr;
  assign mem_wdata = wr_data;

  assign cnt_nxt = (wr_count == DEPTH_C) ? wr_count : wr_count + ONE_C;

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      vblank_q   <= 1'b0;
      frame_done <= 1'b0;
      wr_count   <= '0;
      addr_err   <= 1'b0;
    end else begin
      vblank_q   <= vblank;
      frame_done <= 1'b0;
      if (wr_acc && !wr_in)
        addr_err <= 1'b1;
      unique case (state)
        IDLE: begin
          if (load_req) begin
            if (WAIT_FOR_VBLANK) begin
              state <= WAIT_VB;
            end else begin
              state    <= LOAD;
              wr_count <= '0;
            end
          end
        end
        WAIT_VB: begin
          if (!load_req) begin
            state <= IDLE;
          end else if (vb_rise) begin
            state    <= LOAD;
            wr_count <= '0;
          end
        end
        LOAD: begin
          if (wr_acc)
            wr_count <= cnt_nxt;
          if (wr_acc && cnt_nxt == DEPTH_C) begin
            state      <= IDLE;
            frame_done <= 1'b1;
          end else if (!load_req) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Out-of-range reads never touch the BRAM but still return a zero beat.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      rd_p1    <= 1'b0;
      rd_ok1   <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_p1    <= rd_req;
      rd_ok1   <= rd_req & rd_in;
      rd_valid <= rd_p1;
      rd_data  <= rd_ok1 ? mem_rdata : '0;
    end
  end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter with FB_DEPTH=16.
// A behavioural 1-cycle BRAM sits on the mem_* port.
module tb_fb_port_arbiter;

  localparam int AW = 15;
  localparam int PW = 12;

  logic          clk_100MHz;
  logic          reset_n;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic [PW-1:0] rd_data;
  logic          rd_valid;
  logic          vblank;
  logic          load_req;
  logic          load_gnt;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [PW-1:0] wr_data;
  logic          frame_done;
  logic [AW:0]   wr_count;
  logic          addr_err;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [PW-1:0] mem_wdata;
  logic [PW-1:0] mem_rdata;

  logic [PW-1:0] bram [0:(1<<AW)-1];
  logic [PW-1:0] exp_d [0:15];
  int n_cmp;
  int n_err;
  int fd_cnt;

  fb_port_arbiter #(
    .PIX_W(PW),
    .FB_DEPTH(16),
    .ADDR_W(AW),
    .WAIT_FOR_VBLANK(1'b1)
  ) dut (
    .clk_100MHz(clk_100MHz),
    .reset_n(reset_n),
    .rd_req(rd_req),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .vblank(vblank),
    .load_req(load_req),
    .load_gnt(load_gnt),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .frame_done(frame_done),
    .wr_count(wr_count),
    .addr_err(addr_err),
    .mem_en(mem_en),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk_100MHz = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  always @(posedge clk_100MHz) begin
    if (mem_en) begin
      if (mem_we)
        bram[mem_addr] <= mem_wdata;
      mem_rdata <= bram[mem_addr];
    end
  end

  always @(negedge clk_100MHz)
    if (frame_done) fd_cnt++;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic read_word(input logic [AW-1:0] a, input logic [PW-1:0] d);
    rd_req  = 1'b1;
    rd_addr = a;
    tick();
    rd_req = 1'b0;
    @(negedge clk_100MHz);
    chk("rd_valid_n1", rd_valid, 0);
    tick();
    @(negedge clk_100MHz);
    chk("rd_valid_n2", rd_valid, 1);
    chk($sformatf("rd_data@%0d", a), rd_data, d);
    tick();
    @(negedge clk_100MHz);
    chk("rd_valid_n3", rd_valid, 0);
  endtask

  task automatic write_beat(input logic [AW-1:0] a, input logic [PW-1:0] d,
                            input bit rnd);
    bit acc;
    bit rq;
    acc      = 1'b0;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    for (int c = 0; c < 40 && !acc; c++) begin
      rq      = rnd && ($urandom_range(0, 3) == 0);
      rd_req  = rq;
      rd_addr = AW'($urandom_range(0, 15));
      @(negedge clk_100MHz);
      if (rq) chk("rd_prio", wr_ready, 0);
      acc = wr_ready;
      tick();
    end
    rd_req   = 1'b0;
    wr_valid = 1'b0;
    if (!acc) chk("wr_timeout", 0, 1);
  endtask

  task automatic start_load();
    load_req = 1'b1;
    vblank   = 1'b0;
    tick();
    tick();
    vblank = 1'b1;
    tick();
    vblank = 1'b0;
    chk("start_gnt", load_gnt, 1);
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    fd_cnt   = 0;
    reset_n  = 1'b1;
    rd_req   = 1'b0;
    rd_addr  = '0;
    vblank   = 1'b0;
    load_req = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    foreach (bram[i]) bram[i] = '0;
    bram[5] = 12'hABC;
    #1 reset_n = 1'b0;
    repeat (3) tick();
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_gnt", load_gnt, 0);
    chk("rst_cnt", wr_count, 0);
    @(negedge clk_100MHz);
    reset_n = 1'b1;
    tick();
    @(negedge clk_100MHz);
    chk("idle_frame_done", frame_done, 0);
    chk("idle_addr_err", addr_err, 0);
    chk("idle_wr_ready", wr_ready, 0);
    chk("idle_mem_en", mem_en, 0);
    chk("idle_mem_we", mem_we, 0);
    chk("idle_mem_addr", mem_addr, 0);
    read_word(5, 12'hABC);

    // vblank already high when the load is requested
    vblank = 1'b1;
    tick();
    tick();
    load_req = 1'b1;
    tick();
    tick();
    chk("vb_hold1", load_gnt, 0);
    tick();
    chk("vb_hold2", load_gnt, 0);
    vblank = 1'b0;
    tick();
    chk("vb_low", load_gnt, 0);
    vblank = 1'b1;
    @(negedge clk_100MHz);
    chk("vb_edge", load_gnt, 0);
    tick();
    chk("vb_after_edge", load_gnt, 1);
    vblank = 1'b0;

    // read/write collision
    rd_req   = 1'b1;
    rd_addr  = 7;
    wr_valid = 1'b1;
    wr_addr  = 3;
    wr_data  = 12'h123;
    @(negedge clk_100MHz);
    chk("col_wr_ready", wr_ready, 0);
    chk("col_mem_we", mem_we, 0);
    chk("col_mem_addr", mem_addr, 7);
    tick();
    rd_req = 1'b0;
    @(negedge clk_100MHz);
    chk("col2_wr_ready", wr_ready, 1);
    chk("col2_mem_we", mem_we, 1);
    chk("col2_mem_addr", mem_addr, 3);
    tick();
    wr_valid = 1'b0;
    chk("col_cnt", wr_count, 1);
    load_req = 1'b0;
    tick();
    chk("col_gnt_off", load_gnt, 0);
    chk("col_cnt_held", wr_count, 1);
    read_word(3, 12'h123);

    // full 16-beat session with sprinkled reads
    start_load();
    for (int i = 0; i < 16; i++) begin
      exp_d[i] = 12'h5A0 ^ PW'(i * 37);
      write_beat(AW'(i), exp_d[i], 1'b1);
      if (i == 14) begin
        chk("full_cnt15", wr_count, 15);
        chk("full_gnt15", load_gnt, 1);
      end
    end
    load_req = 1'b0;
    chk("full_done", frame_done, 1);
    chk("full_cnt", wr_count, 16);
    chk("full_idle", load_gnt, 0);
    tick();
    chk("full_done_pulse", frame_done, 0);
    chk("full_fd_cnt", fd_cnt, 1);
    tick();
    tick();
    for (int i = 0; i < 16; i++)
      read_word(AW'(i), exp_d[i]);

    // out-of-range write then abort
    start_load();
    wr_valid = 1'b1;
    wr_addr  = 20;
    wr_data  = 12'hFFF;
    @(negedge clk_100MHz);
    chk("oor_wr_ready", wr_ready, 1);
    chk("oor_mem_we", mem_we, 0);
    chk("oor_mem_en", mem_en, 0);
    tick();
    wr_valid = 1'b0;
    chk("oor_addr_err", addr_err, 1);
    chk("oor_cnt", wr_count, 1);
    for (int i = 0; i < 4; i++)
      write_beat(AW'(i), 12'hE00 + PW'(i), 1'b0);
    load_req = 1'b0;
    tick();
    chk("abort_gnt", load_gnt, 0);
    chk("abort_cnt", wr_count, 5);
    chk("abort_fd_cnt", fd_cnt, 1);
    chk("abort_err_sticky", addr_err, 1);

    // out-of-range read returns a zero beat
    read_word(25, 12'h000);

    // reset in the middle of a session
    start_load();
    write_beat(8, 12'h808, 1'b0);
    write_beat(9, 12'h909, 1'b0);
    wr_valid = 1'b1;
    wr_addr  = 10;
    @(negedge clk_100MHz);
    #2 reset_n = 1'b0;
    #1;
    chk("mrst_gnt", load_gnt, 0);
    chk("mrst_err", addr_err, 0);
    chk("mrst_cnt", wr_count, 0);
    chk("mrst_wr_ready", wr_ready, 0);
    wr_valid = 1'b0;
    load_req = 1'b0;
    tick();
    @(negedge clk_100MHz);
    reset_n = 1'b1;
    tick();
    chk("mrst_fd_cnt", fd_cnt, 1);
    read_word(8, 12'h808);

    // back-to-back reads while the loader is stalled
    start_load();
    wr_valid = 1'b1;
    wr_addr  = 11;
    wr_data  = 12'h0B0;
    for (int c = 0; c < 7; c++) begin
      rd_req  = (c < 4);
      rd_addr = AW'(c);
      if (c >= 4) wr_valid = 1'b0;
      @(negedge clk_100MHz);
      if (c < 4) chk($sformatf("b2b_stall%0d", c), wr_ready, 0);
      if (c >= 2 && c < 6) begin
        chk($sformatf("b2b_valid%0d", c), rd_valid, 1);
        chk($sformatf("b2b_data%0d", c), rd_data, 12'hE00 + PW'(c - 2));
      end else begin
        chk($sformatf("b2b_valid%0d", c), rd_valid, 0);
      end
      tick();
    end
    chk("b2b_cnt", wr_count, 0);
    load_req = 1'b0;
    tick();
    chk("b2b_idle", load_gnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
Shares one single-port frame-buffer BRAM (12-bit RGB444 words, 1-cycle read latency) between two requesters. The VGA scan-out path issues pixel reads and always wins. An image loader (UART/SD side) writes whole frames in valid/ready beats. A load-session FSM optionally holds the start of a frame load until vertical blanking begins, so a new image never tears mid-scan.

Parameters:
PIX_W, 12, pixel word width (RGB444)
FB_DEPTH, 19200, frame-buffer words (160x120, upscaled 4x by scan-out)
ADDR_W, 15, address width; must satisfy 2**ADDR_W >= FB_DEPTH
WAIT_FOR_VBLANK, 1, 1 = load starts on a vblank rising edge; 0 = load starts immediately

Ports:
clk_100MHz  in  1  system clock; the only clock
reset_n  in  1  asynchronous, active-low reset
rd_req  in  1  scan-out read request, single-cycle pulse; may be asserted on consecutive cycles
rd_addr  in  ADDR_W  scan-out read address
rd_data  out  PIX_W  read data, registered
rd_valid  out  1  rd_data valid pulse, exactly 2 cycles after the matching rd_req
vblank  in  1  vertical-blank level from vga_controller, synchronous to clk_100MHz
load_req  in  1  level; loader requests a frame-load session
load_gnt  out  1  high while in LOAD
wr_valid  in  1  loader write beat valid
wr_ready  out  1  arbiter can accept the beat this cycle
wr_addr  in  ADDR_W  write address
wr_data  in  PIX_W  write pixel
frame_done  out  1  1-cycle pulse when a session ends by reaching its full count
wr_count  out  ADDR_W+1  beats accepted in the current or last session
addr_err  out  1  sticky; set by any out-of-range write accepted
mem_en  out  1  BRAM enable
mem_we  out  1  BRAM write enable
mem_addr  out  ADDR_W  BRAM address
mem_wdata  out  PIX_W  BRAM write data
mem_rdata  in  PIX_W  BRAM read data, valid the cycle after a read is issued

Behaviour:
- Reset (reset_n=0, async): state IDLE; rd_data=0; rd_valid=0; frame_done=0; wr_count=0; addr_err=0; vblank_q=0; read pipeline cleared. The mem_* and wr_ready outputs are combinational and evaluate to 0 while rd_req, wr_valid and load_req are 0.
- FSM states: IDLE, WAIT_VB, LOAD.
  - IDLE, load_req=1: go to WAIT_VB if WAIT_FOR_VBLANK=1, else go to LOAD. wr_count is cleared on entry to LOAD.
  - WAIT_VB: go to LOAD on a vblank rising edge (vblank=1 and vblank_q=0). If vblank is already high on entry, wait for the next rising edge. load_req=0 returns to IDLE with no frame_done.
  - LOAD: load_gnt=1. Return to IDLE the cycle after the accepted beat that makes wr_count reach FB_DEPTH; frame_done pulses in that same cycle. load_req=0 also returns to IDLE, with no frame_done and wr_count held.
- Arbitration is fixed priority, with read over write.
  - wr_ready = (state==LOAD) && !rd_req. This is combinational.
  - A write beat is accepted when wr_valid && wr_ready.
  - rd_req and wr_valid in the same cycle: the read is issued and the write stalls. The loader must hold wr_* until accepted.
- mem_en = rd_req | accepted write. mem_we = accepted write. mem_addr = rd_req ? rd_addr : wr_addr. mem_wdata = wr_data.
- Read latency: rd_req at cycle N, BRAM data at N+1, rd_data/rd_valid registered at N+2. Back-to-back requests produce back-to-back rd_valid.
- rd_req is honoured in every state, including during reset release, with no bubbles.
- Out-of-range read (rd_addr >= FB_DEPTH): mem_en stays 0. rd_valid still fires at N+2 with rd_data=0.
- Out-of-range write (wr_addr >= FB_DEPTH) in LOAD: the beat is accepted (wr_ready unchanged) and counted. mem_we stays 0. addr_err is set and cleared only by reset.
- Writes outside LOAD: wr_ready=0 and nothing is accepted.
- wr_count saturates at FB_DEPTH. It is ADDR_W+1 bits wide so it never wraps.
- Reset asserted mid-LOAD: session aborts immediately, no frame_done, and BRAM contents are left as written.

Decomposition:
- Package fb_pkg:
  - constants PIX_W, FB_W=160, FB_H=120, FB_DEPTH, ADDR_W
  - typedef enum logic [1:0] fb_arb_state_t {IDLE, WAIT_VB, LOAD}
  - typedef logic [PIX_W-1:0] pixel_t
- No sub-module is warranted: the FSM, arbitration mux and 2-stage read pipe stay flat. The BRAM itself (fb_bram) lives outside this block.

Test Plan (FB_DEPTH overridden to 16 where noted):
- Reset and read: reset_n low then high; BRAM preloaded addr 5=12'hABC; rd_req pulse with rd_addr=5 -> rd_valid one pulse exactly 2 cycles later, rd_data=12'hABC; all other outputs 0.
- Collision: in LOAD, wr_valid=1 (addr 3, 12'h123) with rd_req=1 on the same cycle -> wr_ready=0, mem_we=0, mem_addr=rd_addr; next cycle with rd_req=0 the write is accepted and readback of addr 3 gives 12'h123.
- Vblank gating (WAIT_FOR_VBLANK=1): load_req=1 while vblank=1 -> load_gnt stays 0 until vblank falls and rises again; load_gnt is 1 the cycle after that rising edge.
- Full session (FB_DEPTH=16): 16 accepted beats with random rd_req at most 1 in 4 cycles -> frame_done single pulse after the 16th beat; wr_count=16; state IDLE; all 16 words read back correctly.
- Abort and errors: a session with one write to addr 20 (FB_DEPTH=16) -> addr_err=1 and no BRAM write. Then load_req dropped after 5 beats -> IDLE, no frame_done, wr_count=5. Then reset_n asserted mid-LOAD -> load_gnt=0 asynchronously and addr_err=0.
- Back-to-back reads: rd_req for 4 consecutive cycles at addrs 0..3 -> 4 consecutive rd_valid pulses with data in order, and no write accepted during those cycles.
